// File: rtl/alu_exec_unit.sv
// alu_exec_unit: MIPS execute-stage ALU with valid/ready handshaking.
//
// Merges ALUOp/funct decode, JR detection and the arithmetic datapath.
// The optional iterative shift-add multiplier is compiled in only when
// the macro ALU_MUL_EN is defined. Without it, funct 0101 decodes as illegal.
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. The sender holds its payload and valid until that transfer.
// The receiver may raise or drop ready at any time.
//
// Ports:
//   clk, reset            clock, asynchronous active-high reset
//   in_valid / in_ready   operation handshake (alu_op, funct, src_a, src_b)
//   out_valid / out_ready result handshake (result, zero, overflow, jr, illegal)
//   o_dbg_state           current FSM state, for debug and checkers
module alu_exec_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [1:0]       alu_op,
   input  logic [3:0]       funct,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             overflow,
   output logic             jr,
   output logic             illegal,
   output logic [1:0]       o_dbg_state
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_DONE = 2'd1;
`ifdef ALU_MUL_EN
   localparam logic [1:0] S_MUL  = 2'd2;
`endif

   localparam logic [2:0] OP_ADD = 3'd0;
   localparam logic [2:0] OP_SUB = 3'd1;
   localparam logic [2:0] OP_AND = 3'd2;
   localparam logic [2:0] OP_OR  = 3'd3;
   localparam logic [2:0] OP_SLT = 3'd4;
   localparam logic [2:0] OP_JR  = 3'd5;
   localparam logic [2:0] OP_ILL = 3'd6;
`ifdef ALU_MUL_EN
   localparam logic [2:0] OP_MUL = 3'd7;
   localparam int CNT_W = $clog2(WIDTH);
`endif

   logic [1:0]       r_state;
   logic [1:0]       w_state_nxt;
   logic [2:0]       w_op;
   logic             w_accept;
   logic [WIDTH-1:0] w_add;
   logic [WIDTH-1:0] w_sub;
   logic [WIDTH-1:0] w_res;
   logic             w_ovf;
   logic             w_jr;
   logic             w_ill;
   logic [WIDTH-1:0] r_result;
   logic             r_zero;
   logic             r_ovf;
   logic             r_jr;
   logic             r_ill;

`ifdef ALU_MUL_EN
   logic [CNT_W-1:0]   r_cnt;
   logic [2*WIDTH-1:0] r_acc;     // {partial high half, remaining multiplier bits}
   logic [WIDTH-1:0]   r_mcand;
   logic [WIDTH:0]     w_sum;
   logic [2*WIDTH-1:0] w_prod;
   logic               w_mul_last;

   // Right-shifting shift-add: the multiplier occupies the low half of the
   // accumulator and its LSB selects whether the multiplicand is added.
   assign w_sum      = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                     + (r_acc[0] ? {1'b0, r_mcand} : {(WIDTH+1){1'b0}});
   assign w_prod     = {w_sum, r_acc[WIDTH-1:1]};
   assign w_mul_last = (r_state == S_MUL) && (r_cnt == CNT_W'(WIDTH-1));
`endif

   // ---------------- decode ----------------
   always_comb begin
      w_op = OP_ILL;
      case (alu_op)
         2'b11:   w_op = OP_ADD;
         2'b10:   w_op = OP_SLT;
         2'b01:   w_op = OP_SUB;
         default: begin
            case (funct)
               4'b0000: w_op = OP_ADD;
               4'b0001: w_op = OP_SUB;
               4'b0010: w_op = OP_AND;
               4'b0011: w_op = OP_OR;
               4'b0100: w_op = OP_SLT;
`ifdef ALU_MUL_EN
               4'b0101: w_op = OP_MUL;
`endif
               4'b1000: w_op = OP_JR;
               default: w_op = OP_ILL;
            endcase
         end
      endcase
   end

   // ---------------- single-cycle datapath ----------------
   assign w_add    = src_a + src_b;
   assign w_sub    = src_a - src_b;
   assign w_accept = in_valid && in_ready;

   always_comb begin
      w_res = '0;
      w_ovf = 1'b0;
      w_jr  = 1'b0;
      w_ill = 1'b0;
      case (w_op)
         OP_ADD: begin
            w_res = w_add;
            w_ovf = (src_a[WIDTH-1] == src_b[WIDTH-1]) && (w_add[WIDTH-1] != src_a[WIDTH-1]);
         end
         OP_SUB: begin
            w_res = w_sub;
            w_ovf = (src_a[WIDTH-1] != src_b[WIDTH-1]) && (w_sub[WIDTH-1] != src_a[WIDTH-1]);
         end
         OP_AND: w_res = src_a & src_b;
         OP_OR:  w_res = src_a | src_b;
         OP_SLT: w_res = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
         OP_JR: begin
            w_res = src_a;
            w_jr  = 1'b1;
         end
         OP_ILL: w_ill = 1'b1;
         default: w_res = '0;
      endcase
   end

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_state_nxt;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE, S_DONE: begin
            if (w_accept) begin
`ifdef ALU_MUL_EN
               w_state_nxt = (w_op == OP_MUL) ? S_MUL : S_DONE;
`else
               w_state_nxt = S_DONE;
`endif
            end else if ((r_state == S_DONE) && out_ready) begin
               w_state_nxt = S_IDLE;
            end
         end
`ifdef ALU_MUL_EN
         S_MUL: if (w_mul_last) w_state_nxt = S_DONE;
`endif
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      out_valid   = (r_state == S_DONE);
      // Forced low during reset so nothing is accepted while the unit is held.
      in_ready    = !reset && ((r_state == S_IDLE) || ((r_state == S_DONE) && out_ready));
      o_dbg_state = r_state;
   end

   // ---------------- result registers ----------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_result <= '0;
         r_zero   <= 1'b0;
         r_ovf    <= 1'b0;
         r_jr     <= 1'b0;
         r_ill    <= 1'b0;
`ifdef ALU_MUL_EN
         r_cnt    <= '0;
         r_acc    <= '0;
         r_mcand  <= '0;
`endif
      end else begin
         if (w_accept) begin
`ifdef ALU_MUL_EN
            if (w_op == OP_MUL) begin
               r_acc   <= {{WIDTH{1'b0}}, src_b};
               r_mcand <= src_a;
               r_cnt   <= '0;
            end else
`endif
            begin
               r_result <= w_res;
               r_zero   <= (w_res == '0);
               r_ovf    <= w_ovf;
               r_jr     <= w_jr;
               r_ill    <= w_ill;
            end
         end
`ifdef ALU_MUL_EN
         else if (r_state == S_MUL) begin
            r_acc <= w_prod;
            // The last step publishes the product directly so the result
            // lands on the same edge the FSM enters DONE.
            if (w_mul_last) begin
               r_result <= w_prod[WIDTH-1:0];
               r_zero   <= (w_prod[WIDTH-1:0] == '0);
               r_ovf    <= |w_prod[2*WIDTH-1:WIDTH];
               r_jr     <= 1'b0;
               r_ill    <= 1'b0;
               r_cnt    <= '0;
            end else begin
               r_cnt    <= r_cnt + CNT_W'(1);
            end
         end
`endif
      end
   end

   assign result   = r_result;
   assign zero     = r_zero;
   assign overflow = r_ovf;
   assign jr       = r_jr;
   assign illegal  = r_ill;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed bench for alu_exec_unit with a result scoreboard.
module tb_alu_exec_unit;

   localparam int W = 32;

   logic         clk = 1'b0;
   logic         reset;
   logic         in_valid;
   logic         in_ready;
   logic [1:0]   alu_op;
   logic [3:0]   funct;
   logic [W-1:0] src_a;
   logic [W-1:0] src_b;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] result;
   logic         zero;
   logic         overflow;
   logic         jr;
   logic         illegal;
   logic [1:0]   dbg_state;

   logic [W+3:0] exp_q[$];
   int           total = 0;
   int           bad   = 0;

   alu_exec_unit #(.WIDTH(W)) dut (
      .clk         (clk),
      .reset       (reset),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .alu_op      (alu_op),
      .funct       (funct),
      .src_a       (src_a),
      .src_b       (src_b),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .result      (result),
      .zero        (zero),
      .overflow    (overflow),
      .jr          (jr),
      .illegal     (illegal),
      .o_dbg_state (dbg_state)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   // ---------------- helpers ----------------
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [W+3:0] pack(input logic [W-1:0] r, input logic o,
                                         input logic j, input logic il);
      return {r, (r == '0), o, j, il};
   endfunction

   // Reference model: wide arithmetic, independent of the RTL structure.
   function automatic logic [W+3:0] model(input logic [1:0] op, input logic [3:0] fn,
                                          input logic [W-1:0] a, input logic [W-1:0] b);
      logic [W:0]     s;
      logic [2*W-1:0] p;
      int             k;
      if (op == 2'b11)      k = 0;
      else if (op == 2'b01) k = 1;
      else if (op == 2'b10) k = 4;
      else begin
         case (fn)
            4'd0: k = 0;
            4'd1: k = 1;
            4'd2: k = 2;
            4'd3: k = 3;
            4'd4: k = 4;
`ifdef ALU_MUL_EN
            4'd5: k = 5;
`endif
            4'd8: k = 6;
            default: k = 7;
         endcase
      end
      case (k)
         0: begin
            s = {a[W-1], a} + {b[W-1], b};
            return pack(s[W-1:0], s[W] != s[W-1], 1'b0, 1'b0);
         end
         1: begin
            s = {a[W-1], a} - {b[W-1], b};
            return pack(s[W-1:0], s[W] != s[W-1], 1'b0, 1'b0);
         end
         2: return pack(a & b, 1'b0, 1'b0, 1'b0);
         3: return pack(a | b, 1'b0, 1'b0, 1'b0);
         4: return pack(($signed(a) < $signed(b)) ? 1 : 0, 1'b0, 1'b0, 1'b0);
         5: begin
            p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
            return pack(p[W-1:0], |p[2*W-1:W], 1'b0, 1'b0);
         end
         6: return pack(a, 1'b0, 1'b1, 1'b0);
         default: return pack('0, 1'b0, 1'b0, 1'b1);
      endcase
   endfunction

   task automatic sync();
      @(posedge clk);
      #1;
   endtask

   // Present one op, wait (bounded) for acceptance, push its expectation.
   // Returns at posedge+1 after the accepting edge.
   task automatic send(input logic [1:0] op, input logic [3:0] fn,
                       input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W+3:0] exp, output int waits);
      alu_op   = op;
      funct    = fn;
      src_a    = a;
      src_b    = b;
      in_valid = 1'b1;
      waits    = 0;
      @(negedge clk);
      while (!in_ready && waits < 200) begin
         waits++;
         @(negedge clk);
      end
      chk("accept_timeout", in_ready, 1'b1);
      if (in_ready) exp_q.push_back(exp);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      // Scramble inputs: the captured operation must not follow them.
      src_a    = $urandom;
      src_b    = $urandom;
      funct    = 4'($urandom_range(0, 15));
   endtask

   // ---------------- scoreboard ----------------
   always @(negedge clk) begin
      if (!reset && out_valid && out_ready) begin
         if (exp_q.size() == 0) chk("sb_unexpected_result", out_valid, 1'b0);
         else chk("sb_result", {result, zero, overflow, jr, illegal}, exp_q.pop_front());
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      int           w;
      logic [1:0]   op;
      logic [3:0]   fn;
      logic [W-1:0] a;
      logic [W-1:0] b;

      reset     = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      alu_op    = 2'b00;
      funct     = 4'b0000;
      src_a     = '0;
      src_b     = '0;
      #2;
      chk("reset_outputs", {result, zero, overflow, jr, illegal, out_valid, in_ready}, '0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      chk("ready_after_reset", in_ready, 1'b1);
      chk("valid_after_reset", out_valid, 1'b0);

      // ADD overflow, latency 1, then back to IDLE
      sync();
      send(2'b11, 4'b0000, 32'h7FFF_FFFF, 32'h1, pack(32'h8000_0000, 1'b1, 1'b0, 1'b0), w);
      @(negedge clk);
      chk("add_latency", out_valid, 1'b1);
      @(negedge clk);
      chk("idle_after_drain", out_valid, 1'b0);

      // SUB to zero, SLT -1 < 1, then R-type ops back to back
      sync();
      send(2'b01, 4'b1111, 32'd5, 32'd5, pack(32'h0, 1'b0, 1'b0, 1'b0), w);
      send(2'b10, 4'b0000, 32'hFFFF_FFFF, 32'h1, pack(32'h1, 1'b0, 1'b0, 1'b0), w);
      chk("b2b_slt_ready", w, 0);
      send(2'b00, 4'b0010, 32'hF0F0_F0F0, 32'hFF00_FF00, pack(32'hF000_F000, 1'b0, 1'b0, 1'b0), w);
      send(2'b00, 4'b0011, 32'h0F0F_0F0F, 32'h00FF_00FF, pack(32'h0FFF_0FFF, 1'b0, 1'b0, 1'b0), w);
      send(2'b00, 4'b0100, 32'h1, 32'hFFFF_FFFF, pack(32'h0, 1'b0, 1'b0, 1'b0), w);
      send(2'b00, 4'b0001, 32'h8000_0000, 32'h1, pack(32'h7FFF_FFFF, 1'b1, 1'b0, 1'b0), w);
      send(2'b00, 4'b0000, 32'd2, 32'd3, pack(32'd5, 1'b0, 1'b0, 1'b0), w);
      send(2'b00, 4'b1000, 32'h0040_0020, 32'h5, pack(32'h0040_0020, 1'b0, 1'b1, 1'b0), w);
      send(2'b00, 4'b0111, 32'h1234, 32'h5, pack(32'h0, 1'b0, 1'b0, 1'b1), w);
      send(2'b00, 4'b1111, 32'hFFFF_FFFF, 32'h1, pack(32'h0, 1'b0, 1'b0, 1'b1), w);
      chk("b2b_ill_ready", w, 0);
      repeat (2) @(negedge clk);

`ifdef ALU_MUL_EN
      // MUL: product truncated, result on edge WIDTH+1 after accept
      sync();
      send(2'b00, 4'b0101, 32'h0001_0000, 32'h0001_0000, pack(32'h0, 1'b1, 1'b0, 1'b0), w);
      for (int k = 0; k < W; k++) begin
         @(negedge clk);
         chk("mul_busy_valid", out_valid, 1'b0);
         chk("mul_busy_ready", in_ready, 1'b0);
      end
      @(negedge clk);
      chk("mul_latency", out_valid, 1'b1);
      sync();
      send(2'b00, 4'b0101, 32'd12345, 32'd678, pack(32'd8369910, 1'b0, 1'b0, 1'b0), w);
      repeat (W + 2) @(negedge clk);
`else
      // Without the multiplier, funct 0101 is illegal with latency 1
      sync();
      send(2'b00, 4'b0101, 32'd7, 32'd9, pack(32'h0, 1'b0, 1'b0, 1'b1), w);
      @(negedge clk);
      chk("mul_off_latency", out_valid, 1'b1);
      @(negedge clk);
`endif

      // Stall in DONE: outputs frozen and nothing accepted
      sync();
      out_ready = 1'b0;
      send(2'b11, 4'b0000, 32'd10, 32'd20, pack(32'd30, 1'b0, 1'b0, 1'b0), w);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("stall_valid", out_valid, 1'b1);
         chk("stall_ready", in_ready, 1'b0);
         chk("stall_hold", {result, zero, overflow, jr, illegal}, pack(32'd30, 1'b0, 1'b0, 1'b0));
      end
      sync();
      out_ready = 1'b1;
      send(2'b00, 4'b0011, 32'h1, 32'h2, pack(32'h3, 1'b0, 1'b0, 1'b0), w);
      chk("release_same_cycle", w, 0);
      send(2'b00, 4'b0010, 32'h6, 32'h3, pack(32'h2, 1'b0, 1'b0, 1'b0), w);
      chk("release_b2b", w, 0);
      repeat (2) @(negedge clk);

      // Random single-cycle ops back to back, checked against the model
      sync();
      for (int i = 0; i < 16; i++) begin
         op = 2'($urandom_range(0, 3));
         fn = 4'($urandom_range(0, 15));
         if (op == 2'b00 && fn == 4'b0101) fn = 4'b0011;
         a  = $urandom;
         b  = (i % 4 == 0) ? a : $urandom;
         send(op, fn, a, b, model(op, fn, a, b), w);
         chk("rand_b2b_ready", w, 0);
      end
      repeat (2) @(negedge clk);

      // Reset in the middle of a long operation aborts it
      sync();
`ifdef ALU_MUL_EN
      send(2'b00, 4'b0101, 32'd99, 32'd77, pack(32'd7623, 1'b0, 1'b0, 1'b0), w);
`else
      out_ready = 1'b0;
      send(2'b11, 4'b0000, 32'd99, 32'd77, pack(32'd176, 1'b0, 1'b0, 1'b0), w);
`endif
      repeat (10) @(negedge clk);
      #1;
      reset = 1'b1;
      #1;
      chk("midop_reset_outputs", {result, zero, overflow, jr, illegal, out_valid, in_ready}, '0);
      void'(exp_q.pop_back());
      out_ready = 1'b1;
      sync();
      reset = 1'b0;
      @(negedge clk);
      chk("ready_after_midop_reset", in_ready, 1'b1);
      chk("no_result_after_abort", out_valid, 1'b0);
      sync();
      send(2'b11, 4'b0000, 32'd2, 32'd3, pack(32'd5, 1'b0, 1'b0, 1'b0), w);
      @(negedge clk);
      chk("post_reset_latency", out_valid, 1'b1);
      @(negedge clk);
      chk("post_reset_idle", out_valid, 1'b0);

      repeat (3) @(negedge clk);
      chk("scoreboard_drained", exp_q.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Parametrised execute-stage ALU for the MIPS processor. It merges ALUOp/funct decode, JR detection and the arithmetic datapath into one handshaked unit, and adds an iterative multi-cycle multiply. It sits between the ID/EX register and the EX/MEM register. The valid/ready handshake lets the pipeline stall while a multiply is in flight.

## Interface
- WIDTH, 32, datapath width in bits (minimum 4)
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  operation presented
- in_ready  output  1  unit can accept an operation this cycle
- alu_op  input  2  ALUOp from main control
- funct  input  4  low funct bits from instruction
- src_a  input  WIDTH  operand A (rs)
- src_b  input  WIDTH  operand B (rt or immediate)
- out_valid  output  1  result available
- out_ready  input  1  downstream accepts result
- result  output  WIDTH  operation result
- zero  output  1  result == 0
- overflow  output  1  signed add/sub overflow, or multiply product truncated
- jr  output  1  operation was JR
- illegal  output  1  undefined R-type funct

## Operation
- Decode of {alu_op, funct}:
  - 11xxxx: ADD
  - 10xxxx: SLT
  - 01xxxx: SUB
  - 00 with funct 0000: ADD
  - 00 with funct 0001: SUB
  - 00 with funct 0010: AND
  - 00 with funct 0011: OR
  - 00 with funct 0100: SLT
  - 00 with funct 0101: MUL
  - 00 with funct 1000: JR
  - 00 with any other funct: ILLEGAL
- Operand and decode capture: on accept (in_valid && in_ready) the operands and decoded op are registered. Later input changes are ignored.
- ADD/SUB: result is modulo 2^WIDTH. overflow is signed overflow.
- AND/OR: bitwise. overflow = 0.
- SLT: signed compare; result = 1 zero-extended, else 0. overflow = 0.
- MUL: unsigned shift-add, one multiplier bit per cycle.
  - result = low WIDTH bits of the product.
  - overflow = 1 if any high WIDTH bit of the 2·WIDTH product is nonzero.
- JR: result = src_a, jr = 1.
- ILLEGAL: result = 0, illegal = 1, no other effect.
- zero is computed from the final registered result.
- FSM states and transitions:
  - IDLE: accepting a single-cycle op → DONE; accepting MUL → MUL.
  - MUL: internal counter runs WIDTH cycles, then → DONE.
  - DONE: out_valid = 1; out_valid && out_ready → IDLE, or straight to DONE/MUL if a new op is accepted in the same cycle.

## Timing
- Reset (asynchronous, immediate): state = IDLE; out_valid, result, zero, overflow, jr, illegal all 0; MUL counter 0. in_ready is forced 0 while reset is high and is 1 in the first cycle after release.
- in_ready = (state == IDLE) || (state == DONE && out_ready). It is 0 throughout MUL.
- Single-cycle ops: out_valid rises on the edge after accept (latency 1). Back-to-back ops sustain one result per cycle while out_ready = 1.
- MUL: out_valid rises WIDTH+1 edges after accept.
- Stall: in DONE with out_ready = 0, result and all flags stay stable and no new op is accepted.
- Reset asserted mid-MUL aborts the operation; no result is produced.
- in_valid deasserted while in DONE and out_ready = 1 → IDLE, out_valid = 0 next cycle.

## Configuration
- ALU_MUL_EN defined: the MUL datapath, counter and MUL state are compiled in; funct 0101 performs MUL.
- ALU_MUL_EN undefined: no multiplier logic; {00,0101} decodes as ILLEGAL with latency 1, and the MUL state does not exist.

## Test plan
- Reset, then ADD 0x7FFFFFFF+1 with WIDTH=32 → result 0x80000000, overflow=1, zero=0, out_valid one cycle after accept.
- SUB (alu_op=01) 5−5 → result 0, zero=1. SLT −1 vs 1 (alu_op=10) → result 1.
- MUL (ALU_MUL_EN) 0x10000 × 0x10000 → result 0, overflow=1, out_valid 33 cycles after accept, in_ready=0 during MUL.
- JR ({00,1000}) src_a=0x00400020 → jr=1, result=0x00400020. Funct 0111 → illegal=1, result 0.
- Hold out_ready=0 for 5 cycles in DONE → outputs stable, in_ready=0. Release → next op accepted in the same cycle, with results back-to-back.
- Assert reset 10 cycles into a MUL → all outputs 0 immediately. After release, an ADD 2+3 returns 5 with latency 1.
